// File: rtl/mole_field_if.sv
// mole_field_if: spawn/whack inputs and mole status outputs of the mole bank.
// master drives requests and buttons, slave is the mole bank itself.
interface mole_field_if #(
  parameter int NUM_MOLES = 8,
  parameter int LIFE_W    = 8,
  parameter int CNT_W     = 8
);
  localparam int IDX_W = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;

  logic                 tick;
  logic                 spawn_en;
  logic [IDX_W-1:0]     spawn_idx;
  logic [LIFE_W-1:0]    spawn_life;
  logic [NUM_MOLES-1:0] whack;
  logic [NUM_MOLES-1:0] active;
  logic [NUM_MOLES-1:0] hit_mask;
  logic [NUM_MOLES-1:0] miss_mask;
  logic                 spawn_err;
  logic [CNT_W-1:0]     hit_count;
  logic [CNT_W-1:0]     miss_count;

  modport master (
    output tick, spawn_en, spawn_idx, spawn_life, whack,
    input  active, hit_mask, miss_mask, spawn_err,
    input  hit_count, miss_count
  );

  modport slave (
    input  tick, spawn_en, spawn_idx, spawn_life, whack,
    output active, hit_mask, miss_mask, spawn_err,
    output hit_count, miss_count
  );
endinterface

// File: rtl/mole_field.sv
// mole_field: bank of self-timing moles with hit/miss resolution.
// MOLE_FIELD_COUNTERS_EN enables the saturating hit/miss counters.
module mole_field #(
  parameter int NUM_MOLES = 8,
  parameter int LIFE_W    = 8,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic clr,
  mole_field_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, UP = 1'b1} st_e;

  st_e                  st_q  [NUM_MOLES];
  st_e                  st_d  [NUM_MOLES];
  logic [LIFE_W-1:0]    tmr_q [NUM_MOLES];
  logic [LIFE_W-1:0]    tmr_d [NUM_MOLES];
  logic [NUM_MOLES-1:0] hit_d, hit_q;
  logic [NUM_MOLES-1:0] miss_d, miss_q;
  logic                 err_d, err_q;
  logic                 idx_ok;
  logic                 tgt_up;

  // Per-mole next state; state is sampled pre-edge so a mole leaving
  // UP this cycle still rejects a spawn aimed at it.
  always_comb begin
    idx_ok = (32'(bus.spawn_idx) < NUM_MOLES);
    tgt_up = 1'b0;
    hit_d  = '0;
    miss_d = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      if (bus.spawn_en && 32'(bus.spawn_idx) == i
          && st_q[i] == UP)
        tgt_up = 1'b1;
      unique case (st_q[i])
        IDLE: begin
          if (bus.spawn_en && 32'(bus.spawn_idx) == i
              && bus.spawn_life != '0) begin
            st_d[i]  = UP;
            tmr_d[i] = bus.spawn_life;
          end
        end
        UP: begin
          if (bus.whack[i]) begin
            st_d[i]  = IDLE;
            tmr_d[i] = '0;
            hit_d[i] = 1'b1;
          end else if (bus.tick) begin
            if (tmr_q[i] == LIFE_W'(1)) begin
              st_d[i]   = IDLE;
              tmr_d[i]  = '0;
              miss_d[i] = 1'b1;
            end else begin
              tmr_d[i] = tmr_q[i] - LIFE_W'(1);
            end
          end
        end
      endcase
    end
    err_d = bus.spawn_en
          && (!idx_ok || bus.spawn_life == '0 || tgt_up);
  end

  // Mole state, timers and event pulse registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_MOLES; i++) begin
        st_q[i]  <= IDLE;
        tmr_q[i] <= '0;
      end
      hit_q  <= '0;
      miss_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MOLES; i++) begin
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
      end
      hit_q  <= hit_d;
      miss_q <= miss_d;
      err_q  <= err_d;
    end
  end

  // active mirrors the registered per-mole state.
  always_comb begin
    bus.active = '0;
    for (int i = 0; i < NUM_MOLES; i++)
      bus.active[i] = (st_q[i] == UP);
  end

  assign bus.hit_mask  = hit_q;
  assign bus.miss_mask = miss_q;
  assign bus.spawn_err = err_q;

`ifdef MOLE_FIELD_COUNTERS_EN
  logic [CNT_W-1:0] hc_q, mc_q;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0]     a,
    input logic [NUM_MOLES-1:0] m
  );
    longint s;
    longint mx;
    mx = (longint'(1) << CNT_W) - 1;
    s  = longint'(a);
    for (int j = 0; j < NUM_MOLES; j++)
      s = s + longint'(m[j]);
    if (s > mx) s = mx;
    return CNT_W'(s);
  endfunction

  // Saturating score counters, updated with the mask pulses.
  always_ff @(posedge clk) begin
    if (clr) begin
      hc_q <= '0;
      mc_q <= '0;
    end else begin
      hc_q <= sat_add(hc_q, hit_d);
      mc_q <= sat_add(mc_q, miss_d);
    end
  end

  assign bus.hit_count  = hc_q;
  assign bus.miss_count = mc_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_mole_field.sv
// tb_mole_field: directed scenarios plus random traffic
// checked against a behavioural mole model.
module tb_mole_field;
  localparam int N = 8;
`ifdef MOLE_FIELD_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  bit   m_up  [N];
  int   m_rem [N];
  int   m_hc, m_mc;
  logic [7:0] m_hit, m_miss;
  bit   m_err;

  mole_field_if #(.NUM_MOLES(8), .LIFE_W(8), .CNT_W(8)) bus ();

  mole_field #(.NUM_MOLES(8), .LIFE_W(8), .CNT_W(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(int v);
    return (v > 255) ? 255 : v;
  endfunction

  // one cycle of the behavioural model, from the rules directly
  task automatic model(bit c, bit t, bit se, int idx, int lf,
                       logic [7:0] wh);
    int nh, nm;
    bit was_up;
    m_hit = '0; m_miss = '0;
    if (c) begin
      foreach (m_up[i]) begin m_up[i] = 0; m_rem[i] = 0; end
      m_hc = 0; m_mc = 0; m_err = 0;
      return;
    end
    was_up = (idx < N) ? m_up[idx] : 0;
    m_err = se && (idx >= N || lf == 0 || was_up);
    nh = 0; nm = 0;
    for (int i = 0; i < N; i++) begin
      if (!m_up[i]) continue;
      if (wh[i]) begin
        m_up[i] = 0; m_hit[i] = 1'b1; nh++;
      end else if (t) begin
        if (m_rem[i] == 1) begin
          m_up[i] = 0; m_miss[i] = 1'b1; nm++;
        end else m_rem[i]--;
      end
    end
    if (se && !m_err) begin
      m_up[idx] = 1; m_rem[idx] = lf;
    end
    m_hc = sat(m_hc + nh);
    m_mc = sat(m_mc + nm);
  endtask

  task automatic step(bit t, bit se, int idx, int lf,
                      logic [7:0] wh, bit c);
    logic [7:0] act;
    clr            = c;
    bus.tick       = t;
    bus.spawn_en   = se;
    bus.spawn_idx  = 3'(idx);
    bus.spawn_life = 8'(lf);
    bus.whack      = wh;
    @(posedge clk);
    model(c, t, se, idx, lf, wh);
    #1;
    act = '0;
    foreach (m_up[i]) act[i] = m_up[i];
    chk("active", 32'(bus.active), 32'(act));
    chk("hit_mask", 32'(bus.hit_mask), 32'(m_hit));
    chk("miss_mask", 32'(bus.miss_mask), 32'(m_miss));
    chk("spawn_err", 32'(bus.spawn_err), 32'(m_err));
    chk("hit_count", 32'(bus.hit_count), CNT_EN ? m_hc : 0);
    chk("miss_count", 32'(bus.miss_count), CNT_EN ? m_mc : 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 8'h00, 1);
    chk("rst_active", 32'(bus.active), 0);
    step(0, 0, 0, 0, 8'h00, 0);

    // lifetime expiry
    step(0, 1, 3, 4, 8'h00, 0);
    chk("s1_up", 32'(bus.active), 32'h08);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 8'h00, 0);
    chk("s1_miss", 32'(bus.miss_mask), 32'h08);
    chk("s1_mcnt", 32'(bus.miss_count), CNT_EN ? 1 : 0);
    step(0, 0, 0, 0, 8'h00, 0);
    chk("s1_pulse", 32'(bus.miss_mask), 0);

    // hit
    step(0, 1, 5, 10, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h20, 0);
    chk("s2_hit", 32'(bus.hit_mask), 32'h20);
    chk("s2_hcnt", 32'(bus.hit_count), CNT_EN ? 1 : 0);
    step(0, 0, 0, 0, 8'h00, 0);

    // hit beats expiry
    step(0, 1, 0, 1, 8'h00, 0);
    step(0, 1, 1, 1, 8'h00, 0);
    step(1, 0, 0, 0, 8'h01, 0);
    chk("s3_hit", 32'(bus.hit_mask), 32'h01);
    chk("s3_miss", 32'(bus.miss_mask), 32'h02);

    // rejected spawns leave mole 2 alone
    step(0, 1, 2, 3, 8'h00, 0);
    step(0, 1, 2, 5, 8'h00, 0);
    chk("s4_err_up", 32'(bus.spawn_err), 1);
    step(0, 1, 2, 0, 8'h00, 0);
    chk("s4_err_0", 32'(bus.spawn_err), 1);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 8'h00, 0);
    chk("s4_miss", 32'(bus.miss_mask), 32'h04);

    // saturation and clear
    for (int k = 0; k < 300; k++) begin
      step(0, 1, k % 8, 5, 8'h00, 0);
      step(0, 0, 0, 0, 8'(1 << (k % 8)), 0);
    end
    chk("s5_sat", 32'(bus.hit_count), CNT_EN ? 255 : 0);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("s5_clr", 32'(bus.hit_count), 0);

    // whack on spawn cycle ignored; clear mid-life
    step(0, 1, 6, 9, 8'h40, 0);
    chk("s6_up", 32'(bus.active), 32'h40);
    chk("s6_nohit", 32'(bus.hit_mask), 0);
    step(1, 0, 0, 0, 8'h00, 0);
    step(1, 1, 6, 2, 8'h00, 1);
    chk("s6_clr", 32'(bus.active), 0);
    step(1, 0, 0, 0, 8'h00, 0);
    chk("s6_nomiss", 32'(bus.miss_mask), 0);

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      logic [7:0] wh;
      wh = '0;
      for (int b = 0; b < N; b++)
        wh[b] = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
           wh, $urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mole_field.md
# mole_field

Parametrised mole-state bank for the Whack-A-Mole processor; the next generation of the plain 8-bit mole register. It holds NUM_MOLES independent moles, each with its own lifetime countdown. It resolves player whacks against raised moles and reports per-mole hit/miss events. It sits between the processor's mole-spawn writes and the button/LED I/O, replacing a bare write-enabled register with self-timing mole behaviour.

## Interface
Parameters:
- NUM_MOLES, 8, number of moles; one state machine and one timer per mole.
- LIFE_W, 8, width of each lifetime timer in ticks.
- CNT_W, 8, width of the hit and miss score counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  reset, synchronous and active-high.
- tick  input  1  time-base strobe, one clk wide; timers decrement only when tick=1.
- spawn_en  input  1  request to raise mole spawn_idx this cycle.
- spawn_idx  input  $clog2(NUM_MOLES)  index of the mole to raise.
- spawn_life  input  LIFE_W  lifetime of the mole in ticks.
- whack  input  NUM_MOLES  level buttons, already synchronised and debounced; bit i = mole i struck.
- active  output  NUM_MOLES  bit i=1 while mole i is UP.
- hit_mask  output  NUM_MOLES  one-cycle pulse per mole hit.
- miss_mask  output  NUM_MOLES  one-cycle pulse per mole expired unhit.
- spawn_err  output  1  one-cycle pulse when a spawn request is rejected.
- hit_count  output  CNT_W  saturating total of hits.
- miss_count  output  CNT_W  saturating total of misses.

## Operation
- Per-mole FSM with two states, IDLE and UP. The timer is LIFE_W bits.
- IDLE -> UP: spawn_en=1, spawn_idx=i, spawn_life!=0 and mole i is IDLE. The timer loads spawn_life.
- Spawn rejection raises spawn_err and leaves state unchanged. A spawn is rejected when any of these hold:
  - mole i is already UP;
  - spawn_life=0;
  - spawn_idx>=NUM_MOLES.
- UP -> IDLE (hit): whack[i]=1 while in UP. This sets hit_mask[i].
- UP -> IDLE (miss): tick=1 and timer==1 with no whack[i]. This sets miss_mask[i].
- UP with tick=1 and timer>1: the timer decrements.
- Whack and expiry in the same cycle: the hit wins, and there is no miss.
- Whack on an IDLE mole, including the spawn cycle itself, is ignored.
- A spawn request that targets a mole leaving UP in the same cycle is rejected, because the state is sampled before the edge.
- hit_count adds popcount(hits this cycle), and miss_count adds popcount(misses this cycle). Both saturate at 2^CNT_W-1 and never wrap.
- Reset is on clr=1 at an edge:
  - all moles go IDLE and all timers go to 0;
  - active, hit_mask, miss_mask, spawn_err, hit_count and miss_count all go to 0;
  - clr overrides any simultaneous spawn, whack or tick.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Spawn accepted at edge k: active[i]=1 from edge k.
- A mole with no whack stays UP for exactly spawn_life tick strobes. active[i] falls at the edge sampling the spawn_life-th tick, and miss_mask[i] pulses for that one cycle.
- whack[i] sampled high at edge k: active[i]=0 and hit_mask[i]=1 from edge k, and hit_mask[i]=0 at edge k+1.
- Counters update at the same edge as the corresponding mask pulse.
- spawn_err pulses for one cycle, at the edge sampling the bad request.
- Throughput is one spawn request per cycle.

## Configuration
- MOLE_FIELD_COUNTERS_EN defined: hit_count and miss_count are implemented as described.
- MOLE_FIELD_COUNTERS_EN undefined:
  - hit_count and miss_count are constant 0 and no counter or popcount logic is synthesised;
  - the ports remain present;
  - all other behaviour is unchanged.

## Test plan
All scenarios use defaults NUM_MOLES=8, LIFE_W=8, CNT_W=8, with counters enabled.
- Spawn idx=3, life=4, then 4 tick strobes with no whack -> active=0x08 for 4 ticks; at the 4th tick, active=0x00, miss_mask=0x08 for one cycle, miss_count=1.
- Spawn idx=5, life=10, whack=0x20 two cycles later -> active=0x00, hit_mask=0x20 for one cycle, hit_count=1, no miss ever.
- Moles 0 and 1 UP with timer=1; tick with whack=0x01 -> hit_mask=0x01, miss_mask=0x02, hit_count=1, miss_count=1.
- Spawn idx=2 while mole 2 is UP, then spawn with life=0 -> spawn_err pulses each time, and active and the timer of mole 2 are unchanged.
- Drive 300 single-mole hits -> hit_count=255, holding there without wrap; then clr=1 for one edge -> all outputs 0.
- Spawn idx=6 with whack=0x40 in the same cycle -> mole 6 UP, no hit; clr asserted mid-life -> active=0, no miss pulse.
